// File: rtl/sram_sp_ctrl_pkg.sv
// Shared state type, default widths and slice helper for the single-port SRAM requester.
package sram_sp_ctrl_pkg;

    localparam int unsigned ADDR_W_DEF     = 9;
    localparam int unsigned DATA_W_DEF     = 80;
    localparam int unsigned MASK_W_DEF     = 8;
    localparam int unsigned RESP_DEPTH_DEF = 3;

    typedef enum logic [0:0] {
        StInit,
        StRun
    } ctrl_state_e;

    function automatic int unsigned slice_w(input int unsigned data_w, input int unsigned mask_w);
        return data_w / mask_w;
    endfunction

endpackage

// File: rtl/sram_resp_fifo.sv
// Small synchronous response FIFO with push/pop/count, async active-low reset.
module sram_resp_fifo #(
    parameter int unsigned DATA_W = 80,
    parameter int unsigned DEPTH  = 3,
    parameter int unsigned CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_push,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_pop,
    output logic [DATA_W-1:0] o_data,
    output logic [CNT_W-1:0]  o_count
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]  r_wptr;
    logic [PTR_W-1:0]  r_rptr;
    logic [CNT_W-1:0]  r_count;
    logic              w_do_push;
    logic              w_do_pop;

    assign w_do_pop  = i_pop && (r_count != '0);
    assign w_do_push = i_push && ((r_count != CNT_FULL) || w_do_pop);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_do_push) begin
                r_wptr <= (r_wptr == PTR_LAST) ? '0 : r_wptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rptr <= (r_rptr == PTR_LAST) ? '0 : r_rptr + 1'b1;
            end
            unique case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset: r_count gates every read of it.
    always_ff @(posedge i_clk) begin
        if (w_do_push) begin
            r_mem[r_wptr] <= i_data;
        end
    end

    assign o_data  = r_mem[r_rptr];
    assign o_count = r_count;

endmodule

// File: rtl/sram_sp_req_ctrl.sv
// Requester-side controller for a single-port RW0 SRAM macro with one-cycle registered read.
// Define SRAM_INIT_EN to sweep the whole array to zero after reset before accepting requests.
module sram_sp_req_ctrl
    import sram_sp_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_W     = ADDR_W_DEF,
    parameter int unsigned DATA_W     = DATA_W_DEF,
    parameter int unsigned MASK_W     = MASK_W_DEF,
    parameter int unsigned RESP_DEPTH = RESP_DEPTH_DEF
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [MASK_W-1:0] req_wmask,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_data,
    output logic              init_done,
    output logic              sram_en,
    output logic              sram_wmode,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [MASK_W-1:0] sram_wmask,
    output logic [DATA_W-1:0] sram_wdata,
    input  logic [DATA_W-1:0] sram_rdata
);

    localparam int unsigned CNT_W = $clog2(RESP_DEPTH + 1);
    localparam int unsigned OCC_W = CNT_W + 1;
    localparam logic [OCC_W-1:0] OCC_MAX = OCC_W'(RESP_DEPTH);

    logic             r_inflight;
    logic [CNT_W-1:0] w_fifo_count;
    logic [OCC_W-1:0] w_occ;
    logic             w_run;
    logic             w_accept;
    logic             w_rd_accept;
    logic             w_pop;

`ifdef SRAM_INIT_EN
    ctrl_state_e       r_state;
    logic [ADDR_W-1:0] r_sweep_addr;
    logic              r_init_done;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= StInit;
            r_sweep_addr <= '0;
            r_init_done  <= 1'b0;
        end else begin
            unique case (r_state)
                StInit: begin
                    r_sweep_addr <= r_sweep_addr + 1'b1;
                    if (&r_sweep_addr) begin
                        r_state     <= StRun;
                        r_init_done <= 1'b1;
                    end
                end
                StRun: r_state <= StRun;
                default: r_state <= StRun;
            endcase
        end
    end

    assign w_run     = (r_state == StRun);
    assign init_done = r_init_done;
`else
    assign w_run     = 1'b1;
    assign init_done = 1'b1;
`endif

    // Occupancy counts the read whose data lands next cycle, so the FIFO can never overflow.
    assign w_occ       = OCC_W'(w_fifo_count) + OCC_W'(r_inflight);
    assign req_ready   = w_run && ((w_occ < OCC_MAX) || req_write);
    assign w_accept    = req_valid && req_ready;
    assign w_rd_accept = w_accept && !req_write;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_inflight <= 1'b0;
        end else begin
            r_inflight <= w_rd_accept;
        end
    end

    always_comb begin
        sram_en    = w_accept;
        sram_wmode = req_write;
        sram_addr  = req_addr;
        sram_wmask = req_wmask;
        sram_wdata = req_wdata;
`ifdef SRAM_INIT_EN
        if (r_state == StInit) begin
            // Gated by reset_n so the macro sees no enable while reset is held.
            sram_en    = reset_n;
            sram_wmode = 1'b1;
            sram_addr  = r_sweep_addr;
            sram_wmask = '1;
            sram_wdata = '0;
        end
`endif
    end

    assign resp_valid = (w_fifo_count != '0);
    assign w_pop      = resp_valid && resp_ready;

    // Macro data is only valid in the cycle after the read; it is pushed then, unconditionally.
    sram_resp_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (RESP_DEPTH),
        .CNT_W  (CNT_W)
    ) u_resp_fifo (
        .i_clk   (clock),
        .i_rst_n (reset_n),
        .i_push  (r_inflight),
        .i_data  (sram_rdata),
        .i_pop   (w_pop),
        .o_data  (resp_data),
        .o_count (w_fifo_count)
    );

endmodule
